// File: rtl/rvfpm_pkg.sv
// Shared types and constants for the rvfpm floating-point model.
// Result bundle layout and flag/register widths used by the result path.
package rvfpm_pkg;

    localparam int FLEN         = 32;
    localparam int X_ID_WIDTH   = 4;
    localparam int NUM_FPU_REGS = 32;
    localparam int FFLAGS_W     = 5;
    localparam int RD_W         = $clog2(NUM_FPU_REGS);

    typedef logic [FFLAGS_W-1:0] rvfpm_fflags_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [RD_W-1:0]       rd;
        logic                  we;
        logic [FLEN-1:0]       data;
        rvfpm_fflags_t         fflags;
    } rvfpm_result_t;

endpackage

// File: rtl/rvfpm_result_fifo.sv
// In-order result FIFO with per-entry kill tagging and head drop.
// The id sits in the top ID_W bits of each stored word.
module rvfpm_result_fifo
    import rvfpm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int DW    = 46
) (
    input  logic            ck,
    input  logic            reset,
    input  logic            push_valid,
    input  logic            push_killed,
    input  logic [DW-1:0]   push_data,
    input  logic            pop,
    input  logic            kill_valid,
    input  logic [ID_W-1:0] kill_id,
    output logic            head_valid,
    output logic            head_killed,
    output logic [DW-1:0]   head_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] killed_q, killed_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_valid) - CW'(pop);
        mem_d    = mem_q;
        killed_d = killed_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_valid && mem_q[i][DW-1 -: ID_W] == kill_id)
                killed_d[i] = 1'b1;
        end
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        // The incoming entry already carries any same-edge kill.
        if (push_valid) begin
            mem_d[wr_ptr_q]    = push_data;
            killed_d[wr_ptr_q] = push_killed;
            wr_ptr_d           = ptr_inc(wr_ptr_q);
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            killed_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            killed_q <= killed_d;
        end
        mem_q <= mem_d;
    end

    always_comb begin
        head_valid  = (count_q != '0);
        head_killed = head_valid && killed_q[rd_ptr_q];
        head_data   = head_valid ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: rtl/rvfpm_result_pipe.sv
// Fixed-latency in-order result pipe: delay line, kill tagging,
// credit-limited issue and a backpressured result port.
module rvfpm_result_pipe
    import rvfpm_pkg::rvfpm_fflags_t;
    import rvfpm_pkg::RD_W;
#(
    parameter int PIPELINE_STAGES = 4,
    parameter int RESULT_DEPTH    = 4,
    parameter int X_ID_WIDTH      = 4,
    parameter int FLEN            = 32
) (
    input  logic                               ck,
    input  logic                               reset,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    input  logic [X_ID_WIDTH-1:0]              issue_id,
    input  logic [4:0]                         issue_rd,
    input  logic                               issue_we,
    input  logic [FLEN-1:0]                    issue_data,
    input  logic [4:0]                         issue_fflags,
    input  logic                               kill_valid,
    input  logic [X_ID_WIDTH-1:0]              kill_id,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [X_ID_WIDTH-1:0]              result_id,
    output logic [4:0]                         result_rd,
    output logic                               result_we,
    output logic [FLEN-1:0]                    result_data,
    output logic [4:0]                         result_fflags,
    output logic                               busy,
    output logic [$clog2(RESULT_DEPTH+1)-1:0]  in_flight
);

    localparam int S  = PIPELINE_STAGES - 1;
    localparam int CW = $clog2(RESULT_DEPTH + 1);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [RD_W-1:0]       rd;
        logic                  we;
        logic [FLEN-1:0]       data;
        rvfpm_fflags_t         fflags;
    } res_t;

    localparam int DW = $bits(res_t);

    logic [CW-1:0] in_flight_q, in_flight_d;
    logic          issue_fire;
    logic          issue_killed;
    res_t          issue_pay;
    logic          push_valid;
    logic          push_killed;
    res_t          push_pay;
    logic          head_valid;
    logic          head_killed;
    res_t          head_pay;
    logic          pop;

    always_comb begin
        issue_ready  = !reset && (in_flight_q < CW'(RESULT_DEPTH));
        issue_fire   = issue_valid && issue_ready;
        issue_killed = kill_valid && (issue_id == kill_id);
        issue_pay    = '{id: issue_id, rd: issue_rd, we: issue_we,
                         data: issue_data, fflags: issue_fflags};
    end

    generate
        if (S == 0) begin : g_direct
            always_comb begin
                push_valid  = issue_fire;
                push_killed = issue_killed;
                push_pay    = issue_pay;
            end
        end else begin : g_line
            logic [S-1:0] valid_q, valid_d;
            logic [S-1:0] killed_q, killed_d;
            res_t         pay_q [S];
            res_t         pay_d [S];

            always_comb begin
                valid_d[0]  = issue_fire;
                killed_d[0] = issue_killed;
                pay_d[0]    = issue_pay;
                for (int i = 1; i < S; i++) begin
                    valid_d[i]  = valid_q[i-1];
                    killed_d[i] = killed_q[i-1] ||
                                  (kill_valid && pay_q[i-1].id == kill_id);
                    pay_d[i]    = pay_q[i-1];
                end
            end

            always_ff @(posedge ck) begin
                if (reset) begin
                    valid_q  <= '0;
                    killed_q <= '0;
                end else begin
                    valid_q  <= valid_d;
                    killed_q <= killed_d;
                end
                pay_q <= pay_d;
            end

            always_comb begin
                push_valid  = valid_q[S-1];
                push_killed = killed_q[S-1] ||
                              (kill_valid && pay_q[S-1].id == kill_id);
                push_pay    = pay_q[S-1];
            end
        end
    endgenerate

    rvfpm_result_fifo #(
        .DEPTH (RESULT_DEPTH),
        .ID_W  (X_ID_WIDTH),
        .DW    (DW)
    ) u_fifo (
        .ck          (ck),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_killed (push_killed),
        .push_data   (push_pay),
        .pop         (pop),
        .kill_valid  (kill_valid),
        .kill_id     (kill_id),
        .head_valid  (head_valid),
        .head_killed (head_killed),
        .head_data   (head_pay)
    );

    // A killed head leaves without waiting for the consumer.
    always_comb begin
        result_valid  = head_valid && !head_killed;
        pop           = head_valid && (head_killed || result_ready);
        result_id     = head_pay.id;
        result_rd     = head_pay.rd;
        result_we     = head_pay.we;
        result_data   = head_pay.data;
        result_fflags = head_pay.fflags;
        in_flight_d   = in_flight_q + CW'(issue_fire) - CW'(pop);
        in_flight     = in_flight_q;
        busy          = (in_flight_q != '0);
    end

    always_ff @(posedge ck) begin
        if (reset)
            in_flight_q <= '0;
        else
            in_flight_q <= in_flight_d;
    end

endmodule

// File: tb/tb_rvfpm_result_pipe.sv
// Bench for rvfpm_result_pipe: directed scenarios plus random traffic,
// compared every cycle against a transaction-queue reference model.
module tb_rvfpm_result_pipe;

    localparam int P = 4;
    localparam int D = 4;

    logic        ck = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_id;
    logic [4:0]  issue_rd;
    logic        issue_we;
    logic [31:0] issue_data;
    logic [4:0]  issue_fflags;
    logic        kill_valid;
    logic [3:0]  kill_id;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_id;
    logic [4:0]  result_rd;
    logic        result_we;
    logic [31:0] result_data;
    logic [4:0]  result_fflags;
    logic        busy;
    logic [2:0]  in_flight;

    always #5 ck = ~ck;

    rvfpm_result_pipe #(
        .PIPELINE_STAGES (P),
        .RESULT_DEPTH    (D),
        .X_ID_WIDTH      (4),
        .FLEN            (32)
    ) dut (
        .ck            (ck),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_id      (issue_id),
        .issue_rd      (issue_rd),
        .issue_we      (issue_we),
        .issue_data    (issue_data),
        .issue_fflags  (issue_fflags),
        .kill_valid    (kill_valid),
        .kill_id       (kill_id),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_id     (result_id),
        .result_rd     (result_rd),
        .result_we     (result_we),
        .result_data   (result_data),
        .result_fflags (result_fflags),
        .busy          (busy),
        .in_flight     (in_flight)
    );

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic [4:0]  ff;
        bit          killed;
        int          arrive;
    } txn_t;

    txn_t q[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   delivered_id2 = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge from the pre-edge inputs, then compare.
    task automatic step();
        bit   fire, hv, rfire, drop, hv2;
        txn_t n;
        fire  = !reset && issue_valid && (q.size() < D);
        hv    = q.size() > 0 && q[0].arrive <= edge_n;
        rfire = !reset && hv && !q[0].killed && result_ready;
        drop  = !reset && hv && q[0].killed;
        @(posedge ck);
        edge_n++;
        if (reset) begin
            q.delete();
        end else begin
            if (rfire || drop)
                void'(q.pop_front());
            if (kill_valid)
                foreach (q[i])
                    if (q[i].id == kill_id)
                        q[i].killed = 1;
            if (fire) begin
                n.id     = issue_id;
                n.rd     = issue_rd;
                n.we     = issue_we;
                n.data   = issue_data;
                n.ff     = issue_fflags;
                n.killed = kill_valid && (kill_id == issue_id);
                n.arrive = edge_n + P - 1;
                q.push_back(n);
            end
        end
        #1;
        hv2 = q.size() > 0 && q[0].arrive <= edge_n;
        if (result_valid && result_id == 4'd2)
            delivered_id2++;
        chk("issue_ready", issue_ready, !reset && (q.size() < D));
        chk("in_flight", in_flight, q.size());
        chk("busy", busy, q.size() != 0);
        chk("result_valid", result_valid, hv2 && !q[0].killed);
        chk("result_id", result_id, hv2 ? q[0].id : 4'd0);
        chk("result_rd", result_rd, hv2 ? q[0].rd : 5'd0);
        chk("result_we", result_we, hv2 ? q[0].we : 1'b0);
        chk("result_data", result_data, hv2 ? q[0].data : 32'd0);
        chk("result_fflags", result_fflags, hv2 ? q[0].ff : 5'd0);
    endtask

    task automatic drive(input bit iv, input int id, input bit kv,
                         input int kid, input bit rr);
        issue_valid  = iv;
        issue_id     = 4'(id);
        issue_rd     = 5'($urandom);
        issue_we     = 1'($urandom);
        issue_data   = $urandom;
        issue_fflags = 5'($urandom);
        kill_valid   = kv;
        kill_id      = 4'(kid);
        result_ready = rr;
        step();
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, 0, rr);
    endtask

    initial begin
        reset        = 1'b1;
        issue_valid  = 1'b0;
        issue_id     = '0;
        issue_rd     = '0;
        issue_we     = 1'b0;
        issue_data   = '0;
        issue_fflags = '0;
        kill_valid   = 1'b0;
        kill_id      = '0;
        result_ready = 1'b0;

        idle(2, 0);
        reset = 1'b0;

        // Latency: single issue at edge 10
        idle(7, 1);
        issue_valid  = 1'b1;
        issue_id     = 4'd3;
        issue_rd     = 5'd7;
        issue_we     = 1'b1;
        issue_data   = 32'h3F80_0000;
        issue_fflags = 5'd0;
        result_ready = 1'b1;
        step();
        chk("lat_edge", edge_n, 10);
        issue_valid = 1'b0;
        step();
        step();
        chk("lat_not_yet", result_valid, 1'b0);
        step();
        chk("lat_valid", result_valid, 1'b1);
        chk("lat_id", result_id, 4'd3);
        chk("lat_data", result_data, 32'h3F80_0000);
        step();
        chk("lat_drained", in_flight, 3'd0);

        // Credit and backpressure
        for (int i = 0; i < 8; i++)
            drive(1, i, 0, 0, 0);
        chk("credit_full", in_flight, 3'd4);
        idle(8, 1);

        // Kill in flight
        drive(1, 1, 0, 0, 1);
        drive(1, 2, 0, 0, 1);
        drive(1, 3, 0, 0, 1);
        delivered_id2 = 0;
        drive(0, 0, 1, 2, 1);
        idle(8, 1);
        chk("kill_no_id2", delivered_id2, 0);

        // Kill at the head under backpressure
        drive(1, 4, 0, 0, 0);
        drive(1, 6, 0, 0, 0);
        idle(5, 0);
        drive(0, 0, 1, 4, 0);
        idle(2, 0);
        idle(3, 1);

        // Same-edge issue and kill, then push/pop with a full FIFO
        drive(1, 5, 1, 5, 1);
        idle(6, 1);
        for (int i = 0; i < 4; i++)
            drive(1, 8 + i, 0, 0, 0);
        idle(4, 0);
        for (int i = 0; i < 10; i++)
            drive(1, i, 0, 0, 1);
        idle(8, 1);

        // Reset with entries in flight
        for (int i = 0; i < 3; i++)
            drive(1, 9 + i, 0, 0, 0);
        reset = 1'b1;
        idle(1, 1);
        reset = 1'b0;
        idle(2, 1);
        drive(1, 12, 0, 0, 1);
        idle(6, 1);

        // Random traffic with a narrow id range to provoke kill hits
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 2)
                reset = 1'b1;
            else
                reset = 1'b0;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3),
                  $urandom_range(0, 9) < 2, $urandom_range(0, 3),
                  $urandom_range(0, 9) < 6);
        end
        reset = 1'b0;
        idle(10, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfpm_result_pipe.md
# rvfpm_result_pipe

Parametrised in-order result pipeline for the rvfpm floating-point model. The model computes each result when the instruction is issued. This block holds the result for a configurable latency, tags it with its transaction ID, and returns results in issue order through a valid/ready result port with backpressure. It supports killing in-flight transactions by ID and uses credit-based issue throttling. It sits between the DPI-C model wrapper (issue side) and the core's CORE-V-XIF result interface.

## Interface
- PIPELINE_STAGES, 4: issue-to-result latency in cycles; legal range 1..16.
- RESULT_DEPTH, 4: output FIFO entries; also the maximum number of transactions in flight. Must be ≥1.
- X_ID_WIDTH, 4: transaction ID width.
- FLEN, 32: result data width.
- ck  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- issue_valid  in  1  a new result is presented.
- issue_ready  out  1  the block can accept a new result.
- issue_id  in  X_ID_WIDTH  transaction ID.
- issue_rd  in  5  destination register index.
- issue_we  in  1  register write enable.
- issue_data  in  FLEN  result value.
- issue_fflags  in  5  exception flags (NV, DZ, OF, UF, NX).
- kill_valid  in  1  kill request.
- kill_id  in  X_ID_WIDTH  ID to kill.
- result_valid  out  1  FIFO head holds a live result.
- result_ready  in  1  consumer accepts the result.
- result_id, result_rd, result_we, result_data, result_fflags  out  as the issue fields  head payload.
- busy  out  1  any transaction is in flight.
- in_flight  out  $clog2(RESULT_DEPTH+1)  current in-flight count.

## Operation
- An issue handshake occurs when issue_valid && issue_ready at a rising edge.
- issue_ready = !reset && (in_flight < RESULT_DEPTH). There is no same-cycle credit from a pop.
- Delay line: PIPELINE_STAGES-1 register stages. Each stage holds {valid, killed, payload}. The line advances every cycle unconditionally and never stalls.
- The last stage writes into the FIFO. With PIPELINE_STAGES=1, the issue writes the FIFO directly.
- Credit throttling guarantees the FIFO never overflows.
- in_flight counts valid delay-line entries plus FIFO entries, killed ones included:
  - increments on an issue handshake;
  - decrements on a result handshake;
  - decrements on a killed-head drop.
- Kill sets the killed bit on every stage and FIFO entry with a matching id, including an entry issued on the same edge.
- Killed entries travel normally. When a killed entry reaches the FIFO head:
  - result_valid stays 0;
  - the entry is dropped at the next edge regardless of result_ready.
- result_valid = head valid && !head killed. The payload outputs show the head fields whenever the FIFO is non-empty, and are 0 when it is empty.
- busy = (in_flight != 0).
- IDs need not be unique. Kill affects every matching entry.

## Timing
- Issue accepted at edge n: result_valid is high in the cycle after edge n+PIPELINE_STAGES-1, provided the FIFO ahead is empty.
- Throughput is one issue per cycle while credit remains.
- Results hold stable while result_valid && !result_ready.
- Reset at edge r clears all valid bits, the FIFO pointers and in_flight. Every output is 0 after edge r. Any handshake at edge r is ignored.
- The FIFO pointers wrap modulo RESULT_DEPTH. Full and empty are distinguished by a count, not by pointer equality.
- Simultaneous events at one edge:
  - FIFO push and pop at the same edge: both occur; the count is unchanged.
  - Issue, result handshake and kill at the same edge: all three apply. in_flight changes by +1-1 net.
  - A kill matching the head while result_valid && result_ready: the result is delivered and counted. The kill affects only other entries.

## Structure
- Package rvfpm_pkg holds:
  - the typedef rvfpm_result_t {id, rd, we, data, fflags}, parametrised via the package constants FLEN and X_ID_WIDTH;
  - the typedef rvfpm_fflags_t;
  - the localparams NUM_FPU_REGS=32 and FFLAGS_W=5.
- Sub-module rvfpm_result_fifo: a synchronous FIFO with a per-entry kill-match port and a head-drop input.
- The delay line and the credit counter stay in the top module.

## Test plan
- Latency: PIPELINE_STAGES=4, a single issue at edge 10 (id 3, data 0x3F800000), result_ready=1 -> result_valid high after edge 13 with id 3 and data 0x3F800000; in_flight returns to 0 after edge 14.
- Credit and backpressure: RESULT_DEPTH=4, result_ready=0, issue every cycle -> exactly 4 accepted and issue_ready=0. Then set result_ready=1 -> results emerge with ids 0,1,2,3 in order, and issue_ready reasserts one cycle after the first pop.
- Kill in flight: issue ids 1,2,3 back-to-back and kill id 2 one cycle later -> ids 1 and 3 are delivered, no result carries id 2, and in_flight ends at 0.
- Kill at the FIFO head while result_ready=0 -> the head is dropped in one cycle, result_valid=0 for that cycle, and the next entry follows.
- Same-edge events: issue id 5 with kill_id 5 -> the entry never produces a result. Push and pop at the same edge with a full FIFO -> no loss and no overflow.
- Reset mid-operation: reset with 3 entries in flight -> all outputs 0 next cycle, no stale results afterwards, and a fresh issue shows normal latency.
